store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of buffered stores; power of two, 2..16.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port cpu_we, input, 1: CPU store request (core mem_w).
REQ-005 SHALL have port cpu_addr, input, 32: CPU data address (core Addr_out).
REQ-006 SHALL have port cpu_wdata, input, 32: store data (core Data_out).
REQ-007 SHALL have port cpu_wea, input, 4: store byte enables (core DWea); bit i covers byte i.
REQ-008 SHALL have port cpu_flush, input, 1: fence request; drain the buffer completely.
REQ-009 SHALL have port cpu_rdata, output, 32: load data to the core (core Data_in).
REQ-010 SHALL have port cpu_stall, output, 1: core must hold its MEM stage.
REQ-011 SHALL have port mem_raddr, output, 32: data-memory combinational read address; always equals cpu_addr.
REQ-012 SHALL have port mem_rdata, input, 32: data-memory read data.
REQ-013 SHALL have ports mem_wreq (output, 1), mem_waddr (output, 32), mem_wdata (output, 32) and mem_wea (output, 4): memory write request and head-entry payload.
REQ-014 SHALL have port mem_wack, input, 1: memory write accept.
REQ-015 SHALL have port stb_count, output, clog2(DEPTH)+1: number of valid entries.

Function
REQ-016 SHALL implement a circular FIFO of DEPTH entries {addr[31:2], data, wea}, with head/tail pointers that wrap modulo DEPTH and an occupancy counter.
REQ-017 SHALL enqueue on a clock edge when cpu_we=1 and cpu_stall=0; a store with cpu_wea=0000 SHALL be discarded and SHALL NOT be enqueued.
REQ-018 SHALL assert cpu_stall when cpu_we=1 and count==DEPTH, regardless of a same-cycle pop; the core retries next cycle.
REQ-019 SHALL drive mem_wreq=1 whenever count>0, with mem_waddr={head.addr,2'b00}, mem_wdata=head.data and mem_wea=head.wea.
REQ-020 SHALL hold the mem_wreq payload stable until acknowledged; a pop occurs on an edge where mem_wreq=1 and mem_wack=1.
REQ-021 SHALL allow simultaneous enqueue and pop (count unchanged); when count==0, a store SHALL NOT bypass the FIFO: it is enqueued, and mem_wreq rises the next cycle (latency 1).
REQ-022 SHALL implement a FSM with states IDLE (count==0), DRAIN (count>0) and FLUSH.
REQ-023 FSM transitions SHALL be: IDLE->DRAIN on enqueue; DRAIN->IDLE when count reaches 0; any state->FLUSH when cpu_flush=1 and count>0; FLUSH->IDLE when count reaches 0.
REQ-024 In FLUSH, SHALL assert cpu_stall and accept no enqueue.
REQ-025 cpu_flush with count==0 SHALL stay in IDLE and SHALL NOT stall.
REQ-026 Address match SHALL compare cpu_addr[31:2] with entry addr; byte offset is ignored.
REQ-027 With forwarding enabled, cpu_rdata byte i SHALL equal byte i of the youngest valid matching entry with wea[i]=1, else mem_rdata byte i; the result is combinational, 0 cycles.
REQ-028 An entry popped in the current cycle SHALL still participate in forwarding during that cycle.

Reset
REQ-029 On reset=0 (asynchronous), SHALL clear head, tail and count to 0, set state=IDLE, and set all entries invalid.
REQ-030 SHALL hold all outputs at reset: mem_wreq=0, cpu_stall=0, stb_count=0, mem_waddr=0, mem_wdata=0, mem_wea=0.
REQ-031 Reset mid-operation SHALL discard buffered stores with no memory write; release is synchronous to clk.

Configuration
REQ-032 SHALL implement forwarding under macro STB_FORWARD_EN: when defined, forwarding per REQ-027.
REQ-033 When STB_FORWARD_EN is undefined, cpu_rdata SHALL equal mem_rdata, and cpu_stall SHALL also assert when cpu_we=0 and cpu_addr matches any valid entry, until no match remains.

Verification
REQ-034 Store A=0x100, D=0x11223344, wea=1111 with mem_wack=1 -> mem_wreq high in cycle+1; the write to 0x100 completes; stb_count returns to 0.
REQ-035 mem_wack=0; issue 5 stores with DEPTH=4 -> 4 accepted; cpu_stall=1 on the 5th; raising mem_wack pops one entry; the 5th is accepted the next cycle.
REQ-036 Buffer 0x200: {0xAA, wea=0001} then {0xBB00, wea=0010}; mem_rdata=0x12345678; load 0x203 -> cpu_rdata=0x1234BBAA (forwarding on) / cpu_stall=1 until drained (forwarding off).
REQ-037 3 entries queued, cpu_flush=1, mem_wack toggled -> state FLUSH, cpu_stall=1 until count=0, then IDLE with cpu_stall=0.
REQ-038 Pointer wrap: 10 back-to-back stores with mem_wack held 1 -> writes emerge in order with correct addr/data; count never exceeds 1.
REQ-039 Assert reset with count=3 -> mem_wreq=0 and stb_count=0 immediately; no write after release.

Source files
------------

// File: rtl/store_buffer_if.sv
// ============================================================================
// store_buffer_if : CPU-side and memory-side signal bundle for store_buffer
// Revision 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface store_buffer_if #(
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             cpu_we;
   logic [31:0]      cpu_addr;
   logic [31:0]      cpu_wdata;
   logic [3:0]       cpu_wea;
   logic             cpu_flush;
   logic [31:0]      cpu_rdata;
   logic             cpu_stall;
   logic [31:0]      mem_raddr;
   logic [31:0]      mem_rdata;
   logic             mem_wreq;
   logic [31:0]      mem_waddr;
   logic [31:0]      mem_wdata;
   logic [3:0]       mem_wea;
   logic             mem_wack;
   logic [CNT_W-1:0] stb_count;

   // Environment side: core plus data memory
   modport master (
      output cpu_we, cpu_addr, cpu_wdata, cpu_wea, cpu_flush, mem_rdata, mem_wack,
      input  cpu_rdata, cpu_stall, mem_raddr, mem_wreq, mem_waddr, mem_wdata, mem_wea, stb_count
   );

   // Store buffer side
   modport slave (
      input  cpu_we, cpu_addr, cpu_wdata, cpu_wea, cpu_flush, mem_rdata, mem_wack,
      output cpu_rdata, cpu_stall, mem_raddr, mem_wreq, mem_waddr, mem_wdata, mem_wea, stb_count
   );
endinterface

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// store_buffer : DEPTH-entry circular store buffer between core and data memory
//                with fence drain; store-to-load forwarding under STB_FORWARD_EN.
// Revision 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   store_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [DEPTH-1:0] valid_q, valid_d;

   logic [29:0]      addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [3:0]       wea_q  [DEPTH];

   logic             not_empty;
   logic             full;
   logic             flush_req;
   logic             hazard;
   logic             stall;
   logic             enq;
   logic             pop;
   logic [DEPTH-1:0] match;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         match[i] = valid_q[i] && (addr_q[i] == bus.cpu_addr[31:2]);
      end
   end

   assign not_empty = (count_q != '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign flush_req = bus.cpu_flush && not_empty;

`ifdef STB_FORWARD_EN
   assign hazard = 1'b0;
`else
   // Without forwarding a load to a buffered address must wait for the drain.
   assign hazard = !bus.cpu_we && (|match);
`endif

   assign stall = (state_q == FLUSH) || flush_req || (bus.cpu_we && full) || hazard;
   assign enq   = bus.cpu_we && !stall && (bus.cpu_wea != 4'b0000);
   assign pop   = not_empty && bus.mem_wack;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      state_d = state_q;

      // enq and pop never target the same slot: empty blocks pop, full blocks enq
      if (enq) begin
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + 1'b1;
      end
      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + 1'b1;
      end

      unique case ({enq, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (flush_req && (count_d != '0)) begin
         state_d = FLUSH;
      end else begin
         unique case (state_q)
            IDLE:    if (enq)              state_d = DRAIN;
            DRAIN:   if (count_d == '0)    state_d = IDLE;
            FLUSH:   if (count_d == '0)    state_d = IDLE;
            default:                       state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   // Payload storage needs no reset: the valid bits and count qualify it.
   always_ff @(posedge clk) begin
      if (enq) begin
         addr_q[tail_q] <= bus.cpu_addr[31:2];
         data_q[tail_q] <= bus.cpu_wdata;
         wea_q[tail_q]  <= bus.cpu_wea;
      end
   end

`ifdef STB_FORWARD_EN
   logic [31:0]      fwd_data;
   logic [PTR_W-1:0] idx;

   // Walk oldest to youngest so younger matching bytes overwrite older ones.
   always_comb begin
      fwd_data = bus.mem_rdata;
      idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PTR_W'(k);
         if (match[idx]) begin
            for (int b = 0; b < 4; b++) begin
               if (wea_q[idx][b]) begin
                  fwd_data[8*b +: 8] = data_q[idx][8*b +: 8];
               end
            end
         end
      end
   end

   assign bus.cpu_rdata = fwd_data;
`else
   assign bus.cpu_rdata = bus.mem_rdata;
`endif

   assign bus.cpu_stall = stall;
   assign bus.mem_raddr = bus.cpu_addr;
   assign bus.mem_wreq  = not_empty;
   assign bus.mem_waddr = not_empty ? {addr_q[head_q], 2'b00} : 32'd0;
   assign bus.mem_wdata = not_empty ? data_q[head_q] : 32'd0;
   assign bus.mem_wea   = not_empty ? wea_q[head_q] : 4'd0;
   assign bus.stb_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// tb_store_buffer : directed stimulus with a write-port scoreboard for store_buffer
// Revision 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_store_buffer;
   localparam int DEPTH = 4;

   logic clk;
   logic reset;

   store_buffer_if #(.DEPTH(DEPTH)) bus ();

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  wea;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  n_checks = 0;
   int  n_fail   = 0;
   int  done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   function automatic wr_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      return {a[31:2], 2'b00, d, w};
   endfunction

   // Monitor: every accepted memory write must match the oldest expected one
   always @(negedge clk) begin
      if (reset === 1'b1 && bus.mem_wreq === 1'b1 && bus.mem_wack === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, no write expected",
                     bus.mem_waddr, bus.mem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", bus.mem_waddr, mon_e.addr);
            check("wr_data", bus.mem_wdata, mon_e.data);
            check("wr_wea",  32'(bus.mem_wea), 32'(mon_e.wea));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
      bus.cpu_wea   = w;
   endtask

   task automatic idle();
      bus.cpu_we    = 1'b0;
      bus.cpu_flush = 1'b0;
      bus.cpu_addr  = 32'd0;
      bus.cpu_wdata = 32'd0;
      bus.cpu_wea   = 4'd0;
   endtask

   task automatic drain(input string name);
      bus.cpu_we   = 1'b0;
      bus.mem_wack = 1'b1;
      for (int i = 0; i < 4*DEPTH; i++) begin
         sample();
         if (bus.stb_count == '0) break;
         step();
      end
      check({name, "_count"}, 32'(bus.stb_count), 32'd0);
      check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b0;
      idle();
      bus.mem_rdata = 32'd0;
      bus.mem_wack  = 1'b0;
      step();
      step();

      // Reset state
      sample();
      check("rst_wreq",  32'(bus.mem_wreq),  32'd0);
      check("rst_stall", 32'(bus.cpu_stall), 32'd0);
      check("rst_count", 32'(bus.stb_count), 32'd0);
      check("rst_waddr", bus.mem_waddr,      32'd0);
      check("rst_wdata", bus.mem_wdata,      32'd0);
      check("rst_wea",   32'(bus.mem_wea),   32'd0);
      step();
      reset = 1'b1;
      step();

      // Single store, immediate accept: no bypass, wreq one cycle later
      bus.mem_wack = 1'b1;
      store(32'h100, 32'h11223344, 4'hF);
      exp_q.push_back(mk(32'h100, 32'h11223344, 4'hF));
      sample();
      check("t1_stall",     32'(bus.cpu_stall), 32'd0);
      check("t1_no_bypass", 32'(bus.mem_wreq),  32'd0);
      step();
      idle();
      sample();
      check("t1_wreq",  32'(bus.mem_wreq),  32'd1);
      check("t1_count", 32'(bus.stb_count), 32'd1);
      check("t1_raddr", bus.mem_raddr,      32'd0);
      step();
      sample();
      check("t1_empty_count", 32'(bus.stb_count), 32'd0);
      check("t1_empty_wreq",  32'(bus.mem_wreq),  32'd0);
      step();

      // Fill to DEPTH, fifth store stalls even while a pop happens
      bus.mem_wack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         store(32'h300 + 32'(4*i), 32'hA0 + 32'(i), 4'hF);
         exp_q.push_back(mk(32'h300 + 32'(4*i), 32'hA0 + 32'(i), 4'hF));
         sample();
         check("t2_accept_stall", 32'(bus.cpu_stall), 32'd0);
         step();
      end
      store(32'h310, 32'hA4, 4'hF);
      sample();
      check("t2_full_stall", 32'(bus.cpu_stall), 32'd1);
      check("t2_full_count", 32'(bus.stb_count), 32'd4);
      step();
      bus.mem_wack = 1'b1;
      sample();
      check("t2_stall_on_pop", 32'(bus.cpu_stall), 32'd1);
      step();
      bus.mem_wack = 1'b0;
      sample();
      check("t2_retry_stall", 32'(bus.cpu_stall), 32'd0);
      check("t2_retry_count", 32'(bus.stb_count), 32'd3);
      exp_q.push_back(mk(32'h310, 32'hA4, 4'hF));
      step();
      idle();
      sample();
      check("t2_refill_count", 32'(bus.stb_count), 32'd4);
      step();
      drain("t2_drain");

      // Byte-merge forwarding / load hazard, wea=0 discard
      bus.mem_wack  = 1'b0;
      bus.mem_rdata = 32'h12345678;
      store(32'h200, 32'h000000AA, 4'b0001);
      exp_q.push_back(mk(32'h200, 32'h000000AA, 4'b0001));
      step();
      store(32'h200, 32'h0000BB00, 4'b0010);
      exp_q.push_back(mk(32'h200, 32'h0000BB00, 4'b0010));
      step();
      idle();
      bus.cpu_addr = 32'h203;
      sample();
`ifdef STB_FORWARD_EN
      check("t3_fwd_rdata", bus.cpu_rdata,        32'h1234BBAA);
      check("t3_fwd_stall", 32'(bus.cpu_stall),   32'd0);
`else
      check("t3_nofwd_rdata",  bus.cpu_rdata,      32'h12345678);
      check("t3_hazard_stall", 32'(bus.cpu_stall), 32'd1);
`endif
      step();
      store(32'h200, 32'h000000CC, 4'b0001);
      exp_q.push_back(mk(32'h200, 32'h000000CC, 4'b0001));
      step();
      store(32'h208, 32'hFFFFFFFF, 4'b0000);
      step();
      idle();
      bus.cpu_addr = 32'h204;
      sample();
      check("t3_discard_count",  32'(bus.stb_count), 32'd3);
      check("t3_nomatch_rdata",  bus.cpu_rdata,      32'h12345678);
      check("t3_nomatch_stall",  32'(bus.cpu_stall), 32'd0);
      step();
      bus.cpu_addr = 32'h201;
      sample();
`ifdef STB_FORWARD_EN
      check("t3_youngest_rdata", bus.cpu_rdata,      32'h1234BBCC);
`else
      check("t3_hazard_stall2",  32'(bus.cpu_stall), 32'd1);
`endif
      step();
      drain("t3_drain");
      sample();
      check("t3_release_stall", 32'(bus.cpu_stall), 32'd0);
      step();

      // Fence: FLUSH stalls and blocks stores until the buffer is empty
      bus.mem_wack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         store(32'h400 + 32'(4*i), 32'h4000 + 32'(i), 4'hF);
         exp_q.push_back(mk(32'h400 + 32'(4*i), 32'h4000 + 32'(i), 4'hF));
         step();
      end
      idle();
      bus.cpu_flush = 1'b1;
      sample();
      check("t4_flush_req_stall", 32'(bus.cpu_stall), 32'd1);
      check("t4_flush_count",     32'(bus.stb_count), 32'd3);
      step();
      bus.cpu_flush = 1'b0;
      store(32'h500, 32'h55, 4'hF);
      sample();
      check("t4_flush_stall", 32'(bus.cpu_stall), 32'd1);
      step();
      sample();
      check("t4_no_enq_in_flush", 32'(bus.stb_count), 32'd3);
      done = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         bus.mem_wack = ~bus.mem_wack;
         sample();
         if (bus.stb_count == '0) begin
            done = 1;
            break;
         end
         check("t4_stall_until_empty", 32'(bus.cpu_stall), 32'd1);
      end
      check("t4_drained",    32'(done),          32'd1);
      check("t4_idle_stall", 32'(bus.cpu_stall), 32'd0);
      exp_q.push_back(mk(32'h500, 32'h55, 4'hF));
      step();
      idle();
      drain("t4_drain");

      // Pointer wrap: ten back-to-back stores with wack held high
      bus.mem_wack = 1'b1;
      for (int i = 0; i < 10; i++) begin
         store(32'h1000 + 32'(4*i), 32'hC0DE0000 + 32'(i) * 32'h01010101, 4'(i + 1));
         exp_q.push_back(mk(32'h1000 + 32'(4*i), 32'hC0DE0000 + 32'(i) * 32'h01010101, 4'(i + 1)));
         sample();
         check("t5_stall",      32'(bus.cpu_stall),       32'd0);
         check("t5_count_le1",  32'(bus.stb_count <= 1),  32'd1);
         step();
      end
      idle();
      drain("t5_drain");

      // Asynchronous reset with three stores pending: they are discarded
      bus.mem_wack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         store(32'h600 + 32'(4*i), 32'h6000 + 32'(i), 4'hF);
         step();
      end
      idle();
      sample();
      check("t6_pre_count", 32'(bus.stb_count), 32'd3);
      check("t6_pre_wreq",  32'(bus.mem_wreq),  32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("t6_rst_wreq",  32'(bus.mem_wreq),  32'd0);
      check("t6_rst_count", 32'(bus.stb_count), 32'd0);
      check("t6_rst_waddr", bus.mem_waddr,      32'd0);
      bus.mem_wack = 1'b1;
      step();
      step();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sample();
         check("t6_post_wreq", 32'(bus.mem_wreq), 32'd0);
         step();
      end

      check("end_pending", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
